// File: rtl/aes_key_schedule.sv
// aes_key_schedule: FIPS-197 key expansion, one 32-bit word per cycle, random-access round-key read.
// Build option: define AES_KEY256_EN for 192/256-bit keys (60-word store); otherwise AES-128 only.

module aes_key_schedule #(
  parameter int RD_REG = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         done,
  output logic         key_err,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rd_round,
  output logic [127:0] round_key
);

`ifdef AES_KEY256_EN
  localparam int NW = 60;
`else
  localparam int NW = 44;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_s;

  logic [31:0]  mem_r [0:NW-1];
  logic [5:0]   idx_r;
  logic [2:0]   phase_r;
  logic [3:0]   nk_r;
  logic [7:0]   rcon_r;
  logic         key_ready_r;
  logic         done_r;
  logic         key_err_r;
  logic [3:0]   num_rounds_r;

  logic         accept_s;
  logic         legal_s;
  logic [3:0]   nk_s;
  logic [3:0]   nr_s;
  logic [31:0]  prev_s;
  logic [31:0]  back_s;
  logic [31:0]  sub_in_s;
  logic [31:0]  sub_out_s;
  logic [31:0]  temp_s;
  logic [31:0]  new_word_s;
  logic [5:0]   last_idx_s;
  logic         gen_last_s;
  logic [5:0]   base_s;
  logic [127:0] rd_data_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    legal_s = 1'b0;
    nk_s    = 4'd4;
    nr_s    = 4'd0;
    case (key_len)
      2'b00: begin
        legal_s = 1'b1;
        nk_s    = 4'd4;
        nr_s    = 4'd10;
      end
`ifdef AES_KEY256_EN
      2'b01: begin
        legal_s = 1'b1;
        nk_s    = 4'd6;
        nr_s    = 4'd12;
      end
      2'b10: begin
        legal_s = 1'b1;
        nk_s    = 4'd8;
        nr_s    = 4'd14;
      end
`endif
      default: begin
        legal_s = 1'b0;
        nk_s    = 4'd4;
        nr_s    = 4'd0;
      end
    endcase
  end

  assign accept_s   = key_valid && key_ready_r;
  assign prev_s     = mem_r[idx_r - 6'd1];
  assign back_s     = mem_r[idx_r - {2'b00, nk_r}];
  assign sub_in_s   = (phase_r == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
  // last word index is 4*Nr+3
  assign last_idx_s = {num_rounds_r, 2'b11};
  assign gen_last_s = (idx_r == last_idx_s);

  byteSub u_sub (
    .word    (sub_in_s),
    .subword (sub_out_s)
  );

  always_comb begin
    if (phase_r == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((nk_r == 4'd8) && (phase_r == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = prev_s;
    end
  end

  assign new_word_s = back_s ^ temp_s;

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_s = legal_s ? GEN : IDLE;
        end else begin
          state_s = state_r;
        end
      end
      GEN: begin
        if (gen_last_s) begin
          state_s = DONE;
        end else begin
          state_s = GEN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      key_ready_r  <= 1'b1;
      done_r       <= 1'b0;
      key_err_r    <= 1'b0;
      num_rounds_r <= 4'd0;
      idx_r        <= 6'd0;
      phase_r      <= 3'd0;
      nk_r         <= 4'd4;
      rcon_r       <= 8'h01;
    end else begin
      state_r     <= state_s;
      key_ready_r <= (state_s != GEN);
      if (accept_s) begin
        done_r       <= 1'b0;
        key_err_r    <= !legal_s;
        num_rounds_r <= nr_s;
        nk_r         <= nk_s;
        idx_r        <= {2'b00, nk_s};
        phase_r      <= 3'd0;
        rcon_r       <= 8'h01;
      end else if (state_r == GEN) begin
        idx_r   <= idx_r + 6'd1;
        // nk_r[2:0]-1 wraps 8 to 7, so one compare covers all key sizes
        phase_r <= (phase_r == (nk_r[2:0] - 3'd1)) ? 3'd0 : (phase_r + 3'd1);
        if (phase_r == 3'd0) begin
          rcon_r <= xtime(rcon_r);
        end else begin
          rcon_r <= rcon_r;
        end
        if (gen_last_s) begin
          done_r <= 1'b1;
        end else begin
          done_r <= done_r;
        end
      end else begin
        done_r <= done_r;
      end
    end
  end

  // Word store needs no reset: its contents are masked by done until rewritten.
  always_ff @(posedge clk) begin
    if (accept_s && legal_s) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(nk_s)) begin
          mem_r[k] <= key_in[255 - 32*k -: 32];
        end
      end
    end else if (state_r == GEN) begin
      mem_r[idx_r] <= new_word_s;
    end
  end

  assign base_s = {rd_round, 2'b00};

  always_comb begin
    rd_data_s = 128'h0;
    if (done_r && (rd_round <= num_rounds_r)) begin
      rd_data_s = {mem_r[base_s], mem_r[base_s + 6'd1], mem_r[base_s + 6'd2], mem_r[base_s + 6'd3]};
    end else begin
      rd_data_s = 128'h0;
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [127:0] round_key_r;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          round_key_r <= 128'h0;
        end else begin
          round_key_r <= rd_data_s;
        end
      end
      assign round_key = round_key_r;
    end else begin : g_rd_comb
      assign round_key = rd_data_s;
    end
  endgenerate

  assign key_ready  = key_ready_r;
  assign done       = done_r;
  assign key_err    = key_err_r;
  assign num_rounds = num_rounds_r;

endmodule

// 32-bit S-box slice: GF(2^8) inverse (x^254) followed by the AES affine map, per byte.
module byteSub (
  input  logic [31:0] word,
  output logic [31:0] subword
);

  function automatic logic [7:0] gf_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      p = p ^ (t & {8{b[k]}});
      t = gf_xt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = gf_inv(x);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    subword = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed self-checking bench for aes_key_schedule using FIPS-197 key expansion vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] key_in = 256'h0;
  logic [1:0]   key_len = 2'b00;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         done;
  logic         key_err;
  logic [3:0]   num_rounds;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] round_key;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [255:0] K128   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] R128_0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K192   = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [127:0] R192_0 = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_C = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_0 = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_1 = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_E = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_schedule #(.RD_REG(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_in     (key_in),
    .key_len    (key_len),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .done       (done),
    .key_err    (key_err),
    .num_rounds (num_rounds),
    .rd_round   (rd_round),
    .round_key  (round_key)
  );

  always #5 clk = ~clk;

  // Offer a key at a negedge; returns ready seen before the offer and ready/done just after the accept edge.
  task automatic offer_key(input logic [255:0] k, input logic [1:0] len, input logic hold,
                           output logic rdy_before, output logic rdy_after, output logic done_after);
    @(negedge clk);
    rdy_before = key_ready;
    key_in = k;
    key_len = len;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) key_valid = 1'b0;
    rdy_after = key_ready;
    done_after = done;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic read_round(input logic [3:0] r, output logic [127:0] k);
    @(negedge clk);
    rd_round = r;
    @(posedge clk);
    #1;
    k = round_key;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", key_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", key_err); end
    n_checks++; if (num_rounds !== 4'd0) begin n_fail++; $display("FAIL reset_nr: got %0d want 0", num_rounds); end
    n_checks++; if (round_key !== 128'h0) begin n_fail++; $display("FAIL reset_rk: got %h want 0", round_key); end
    reset_n = 1'b1;
  endtask

  task automatic test_aes128;
    logic rb, ra, da;
    int lat;
    logic [127:0] k;
    offer_key(K128, 2'b00, 1'b0, rb, ra, da);
    n_checks++; if (rb !== 1'b1) begin n_fail++; $display("FAIL a128_ready_idle: got %b want 1", rb); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL a128_ready_gen: got %b want 0", ra); end
    wait_done(lat);
    n_checks++; if (lat !== 40) begin n_fail++; $display("FAIL a128_latency: got %0d want 40", lat); end
    n_checks++; if (num_rounds !== 4'd10) begin n_fail++; $display("FAIL a128_nr: got %0d want 10", num_rounds); end
    n_checks++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL a128_err: got %b want 0", key_err); end
    read_round(4'd0, k);
    n_checks++; if (k !== R128_0) begin n_fail++; $display("FAIL a128_r0: got %h want %h", k, R128_0); end
    read_round(4'd1, k);
    n_checks++; if (k !== R128_1) begin n_fail++; $display("FAIL a128_r1: got %h want %h", k, R128_1); end
    read_round(4'd10, k);
    n_checks++; if (k !== R128_A) begin n_fail++; $display("FAIL a128_r10: got %h want %h", k, R128_A); end
    read_round(4'd11, k);
    n_checks++; if (k !== 128'h0) begin n_fail++; $display("FAIL a128_r11: got %h want 0", k); end
  endtask

`ifdef AES_KEY256_EN
  task automatic test_aes192;
    logic rb, ra, da;
    int lat;
    logic [127:0] k;
    offer_key(K192, 2'b01, 1'b0, rb, ra, da);
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL a192_done_drop: got %b want 0", da); end
    wait_done(lat);
    n_checks++; if (lat !== 46) begin n_fail++; $display("FAIL a192_latency: got %0d want 46", lat); end
    n_checks++; if (num_rounds !== 4'd12) begin n_fail++; $display("FAIL a192_nr: got %0d want 12", num_rounds); end
    read_round(4'd0, k);
    n_checks++; if (k !== R192_0) begin n_fail++; $display("FAIL a192_r0: got %h want %h", k, R192_0); end
    read_round(4'd12, k);
    n_checks++; if (k !== R192_C) begin n_fail++; $display("FAIL a192_r12: got %h want %h", k, R192_C); end
    read_round(4'd13, k);
    n_checks++; if (k !== 128'h0) begin n_fail++; $display("FAIL a192_r13: got %h want 0", k); end
  endtask

  task automatic test_aes256;
    logic rb, ra, da;
    int lat;
    logic [127:0] k;
    offer_key(K256, 2'b10, 1'b0, rb, ra, da);
    wait_done(lat);
    n_checks++; if (lat !== 52) begin n_fail++; $display("FAIL a256_latency: got %0d want 52", lat); end
    n_checks++; if (num_rounds !== 4'd14) begin n_fail++; $display("FAIL a256_nr: got %0d want 14", num_rounds); end
    read_round(4'd0, k);
    n_checks++; if (k !== R256_0) begin n_fail++; $display("FAIL a256_r0: got %h want %h", k, R256_0); end
    read_round(4'd1, k);
    n_checks++; if (k !== R256_1) begin n_fail++; $display("FAIL a256_r1: got %h want %h", k, R256_1); end
    read_round(4'd14, k);
    n_checks++; if (k !== R256_E) begin n_fail++; $display("FAIL a256_r14: got %h want %h", k, R256_E); end
    read_round(4'd15, k);
    n_checks++; if (k !== 128'h0) begin n_fail++; $display("FAIL a256_r15: got %h want 0", k); end
  endtask
`else
  task automatic test_compiled_out;
    logic rb, ra, da;
    logic [127:0] k;
    offer_key(K192, 2'b01, 1'b0, rb, ra, da);
    n_checks++; if (key_err !== 1'b1) begin n_fail++; $display("FAIL co192_err: got %b want 1", key_err); end
    n_checks++; if (num_rounds !== 4'd0) begin n_fail++; $display("FAIL co192_nr: got %0d want 0", num_rounds); end
    n_checks++; if (ra !== 1'b1 || da !== 1'b0) begin n_fail++; $display("FAIL co192_state: got ready=%b done=%b want 1/0", ra, da); end
    offer_key(K256, 2'b10, 1'b0, rb, ra, da);
    n_checks++; if (key_err !== 1'b1) begin n_fail++; $display("FAIL co256_err: got %b want 1", key_err); end
    read_round(4'd0, k);
    n_checks++; if (k !== 128'h0) begin n_fail++; $display("FAIL co256_rk: got %h want 0", k); end
  endtask
`endif

  task automatic test_illegal;
    logic rb, ra, da;
    int lat;
    logic [127:0] k;
    offer_key(K128, 2'b11, 1'b0, rb, ra, da);
    n_checks++; if (key_err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", key_err); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL ill_done: got %b want 0", da); end
    n_checks++; if (num_rounds !== 4'd0) begin n_fail++; $display("FAIL ill_nr: got %0d want 0", num_rounds); end
    n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b want 1", ra); end
    read_round(4'd0, k);
    n_checks++; if (k !== 128'h0) begin n_fail++; $display("FAIL ill_rk: got %h want 0", k); end
    offer_key(K128, 2'b00, 1'b0, rb, ra, da);
    n_checks++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL ill_clear: got %b want 0", key_err); end
    wait_done(lat);
    n_checks++; if (lat !== 40) begin n_fail++; $display("FAIL ill_reload_lat: got %0d want 40", lat); end
  endtask

  task automatic test_reset_mid_gen;
    logic rb, ra, da;
    int lat;
    logic [127:0] k;
    offer_key(K256, 2'b00, 1'b0, rb, ra, da);
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (done !== 1'b0 || key_ready !== 1'b1) begin n_fail++; $display("FAIL rst_gen_state: got done=%b ready=%b want 0/1", done, key_ready); end
    n_checks++; if (num_rounds !== 4'd0) begin n_fail++; $display("FAIL rst_gen_nr: got %0d want 0", num_rounds); end
    @(negedge clk);
    reset_n = 1'b1;
    offer_key(K128, 2'b00, 1'b0, rb, ra, da);
    wait_done(lat);
    n_checks++; if (lat !== 40) begin n_fail++; $display("FAIL rst_reload_lat: got %0d want 40", lat); end
    read_round(4'd10, k);
    n_checks++; if (k !== R128_A) begin n_fail++; $display("FAIL rst_reload_r10: got %h want %h", k, R128_A); end
    read_round(4'd11, k);
    n_checks++; if (k !== 128'h0) begin n_fail++; $display("FAIL rst_reload_r11: got %h want 0", k); end
  endtask

  task automatic test_back_to_back;
    logic rb, ra, da;
    int lat;
    logic [127:0] k;
    offer_key(K128, 2'b00, 1'b1, rb, ra, da);
    wait_done(lat);
    n_checks++; if (lat !== 40) begin n_fail++; $display("FAIL b2b_first_lat: got %0d want 40", lat); end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    n_checks++; if (done !== 1'b0 || key_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept: got done=%b ready=%b want 0/0", done, key_ready); end
    wait_done(lat);
    n_checks++; if (lat !== 40) begin n_fail++; $display("FAIL b2b_second_lat: got %0d want 40", lat); end
    read_round(4'd10, k);
    n_checks++; if (k !== R128_A) begin n_fail++; $display("FAIL b2b_r10: got %h want %h", k, R128_A); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_aes128();
`ifdef AES_KEY256_EN
    test_aes192();
    test_aes256();
`else
    test_compiled_out();
`endif
    test_illegal();
    test_reset_mid_gen();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
